// File: rtl/urng_pair_packer.sv
// urng_pair_packer
// Pairs consecutive 32-bit uniform words into Box-Muller operand sets
// (48-bit u0, 16-bit u1) and buffers them in a small FIFO. The generator
// cannot be stalled, so a pair that finds the FIFO full is dropped and
// counted. The FSM still returns to WAIT_A after a drop, which keeps the
// word alignment fixed.
module urng_pair_packer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     in_valid,
    input  logic [31:0]              in_data,
    output logic                     pair_valid,
    input  logic                     pair_ready,
    output logic [47:0]              u0,
    output logic [15:0]              u1,
    output logic [$clog2(DEPTH):0]   fill,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic [CNT_W-1:0]         fix_cnt
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   FILL_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   FILL_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic {
        WAIT_A = 1'b0,
        WAIT_B = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [31:0]       hold_a_reg, hold_a_next;
    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [PTR_W:0]    fill_reg, fill_next;
    logic [CNT_W-1:0]  drop_cnt_reg, drop_cnt_next;
    logic [CNT_W-1:0]  fix_cnt_reg, fix_cnt_next;

    // Pair storage: {u0, u1} per entry. Only entries below fill are ever
    // presented, so the array itself needs no reset.
    logic [63:0]       mem [DEPTH];

    logic              pair_formed;
    logic [47:0]       formed_u0;
    logic [47:0]       fixed_u0;
    logic              zero_u0;
    logic              full;
    logic              do_pop;
    logic              do_push;
    logic              do_drop;
    logic [63:0]       head;

    // Pairing FSM: first word goes to hold_a, second word completes the pair.
    always_comb begin
        state_next  = state_reg;
        hold_a_next = hold_a_reg;
        pair_formed = 1'b0;
        if (in_valid) begin
            case (state_reg)
                WAIT_A: begin
                    hold_a_next = in_data;
                    state_next  = WAIT_B;
                end
                WAIT_B: begin
                    pair_formed = 1'b1;
                    state_next  = WAIT_A;
                end
                default: state_next = WAIT_A;
            endcase
        end
    end

    // Pair formation, zero fix, push/pop/drop decisions and counter updates.
    always_comb begin
        formed_u0     = {hold_a_reg, in_data[31:16]};
        zero_u0       = (formed_u0 == 48'd0);
        fixed_u0      = zero_u0 ? 48'd1 : formed_u0;
        full          = (fill_reg == FILL_FULL);
        do_pop        = pair_valid && pair_ready;
        do_push       = pair_formed && (!full || do_pop);
        do_drop       = pair_formed && !do_push;

        wr_ptr_next   = do_push ? wr_ptr_reg + PTR_ONE : wr_ptr_reg;
        rd_ptr_next   = do_pop  ? rd_ptr_reg + PTR_ONE : rd_ptr_reg;

        fill_next     = fill_reg;
        if (do_push && !do_pop) begin
            fill_next = fill_reg + FILL_ONE;
        end else if (!do_push && do_pop) begin
            fill_next = fill_reg - FILL_ONE;
        end

        drop_cnt_next = drop_cnt_reg;
        if (do_drop && (drop_cnt_reg != CNT_MAX)) begin
            drop_cnt_next = drop_cnt_reg + CNT_ONE;
        end

        // The fix is counted for every formed zero pair, dropped or not.
        fix_cnt_next  = fix_cnt_reg;
        if (pair_formed && zero_u0 && (fix_cnt_reg != CNT_MAX)) begin
            fix_cnt_next = fix_cnt_reg + CNT_ONE;
        end
    end

    // Control state: async active-low reset, synchronous clear with the same effect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= WAIT_A;
            hold_a_reg   <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            fill_reg     <= '0;
            drop_cnt_reg <= '0;
            fix_cnt_reg  <= '0;
        end else if (clr) begin
            state_reg    <= WAIT_A;
            hold_a_reg   <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            fill_reg     <= '0;
            drop_cnt_reg <= '0;
            fix_cnt_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            hold_a_reg   <= hold_a_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            fill_reg     <= fill_next;
            drop_cnt_reg <= drop_cnt_next;
            fix_cnt_reg  <= fix_cnt_next;
        end
    end

    // FIFO write port; a push blocked by clear is harmless since fill returns to 0.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= {fixed_u0, in_data[15:0]};
        end
    end

    // Head is read combinationally so a pair is visible the cycle after its push.
    always_comb begin
        head       = mem[rd_ptr_reg];
        pair_valid = (fill_reg != '0);
        u0         = pair_valid ? head[63:16] : 48'd0;
        u1         = pair_valid ? head[15:0]  : 16'd0;
        fill       = fill_reg;
        drop_cnt   = drop_cnt_reg;
        fix_cnt    = fix_cnt_reg;
    end

endmodule

// File: tb/tb_urng_pair_packer.sv
// Directed testbench for urng_pair_packer (DEPTH=4, CNT_W=4 so counter
// saturation is reachable in a short run).
module tb_urng_pair_packer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic        clk;
    logic        reset;
    logic        clr;
    logic        in_valid;
    logic [31:0] in_data;
    logic        pair_valid;
    logic        pair_ready;
    logic [47:0] u0;
    logic [15:0] u1;
    logic [2:0]  fill;
    logic [3:0]  drop_cnt;
    logic [3:0]  fix_cnt;

    int tests_run;
    int tests_failed;

    urng_pair_packer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .pair_valid (pair_valid),
        .pair_ready (pair_ready),
        .u0         (u0),
        .u1         (u1),
        .fill       (fill),
        .drop_cnt   (drop_cnt),
        .fix_cnt    (fix_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Test word generator: distinct, never-zero words.
    function automatic logic [31:0] wd(input int i);
        logic [31:0] v;
        v = 32'h10A55A00 + (32'(i) << 24) + 32'(i);
        return v;
    endfunction

    function automatic logic [47:0] exp_u0(input logic [31:0] a, input logic [31:0] b);
        return {a, b[31:16]};
    endfunction

    function automatic logic [15:0] exp_u1(input logic [31:0] b);
        return b[15:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [31:0] w, input logic rdy);
        in_valid   = 1'b1;
        in_data    = w;
        pair_ready = rdy;
        tick();
        in_valid   = 1'b0;
        pair_ready = 1'b0;
    endtask

    task automatic pop_one();
        pair_ready = 1'b1;
        tick();
        pair_ready = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        tests_run++; if (pair_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got=%b exp=0", pair_valid); end
        tests_run++; if (u0 !== 48'd0) begin tests_failed++; $display("FAIL reset_u0 got=%h exp=0", u0); end
        tests_run++; if (u1 !== 16'd0) begin tests_failed++; $display("FAIL reset_u1 got=%h exp=0", u1); end
        tests_run++; if (fill !== 3'd0) begin tests_failed++; $display("FAIL reset_fill got=%0d exp=0", fill); end
        tests_run++; if (drop_cnt !== 4'd0 || fix_cnt !== 4'd0) begin tests_failed++; $display("FAIL reset_cnts got=%h/%h exp=0/0", drop_cnt, fix_cnt); end
        reset = 1'b1;
        tick();
        $display("[TB] test_reset done");
    endtask

    task automatic test_basic_pair();
        feed(32'h12345678, 1'b0);
        tests_run++; if (pair_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_half_valid got=%b exp=0", pair_valid); end
        feed(32'h9ABCDEF0, 1'b0);
        tests_run++; if (pair_valid !== 1'b1) begin tests_failed++; $display("FAIL basic_valid got=%b exp=1", pair_valid); end
        tests_run++; if (u0 !== 48'h123456789ABC) begin tests_failed++; $display("FAIL basic_u0 got=%h exp=123456789abc", u0); end
        tests_run++; if (u1 !== 16'hDEF0) begin tests_failed++; $display("FAIL basic_u1 got=%h exp=def0", u1); end
        tests_run++; if (fill !== 3'd1) begin tests_failed++; $display("FAIL basic_fill got=%0d exp=1", fill); end
        pop_one();
        tests_run++; if (pair_valid !== 1'b0 || u0 !== 48'd0 || u1 !== 16'd0 || fill !== 3'd0) begin
            tests_failed++; $display("FAIL basic_after_pop got v=%b u0=%h u1=%h fill=%0d exp 0/0/0/0", pair_valid, u0, u1, fill); end
        pop_one();
        tests_run++; if (fill !== 3'd0 || pair_valid !== 1'b0) begin tests_failed++; $display("FAIL pop_empty got fill=%0d v=%b exp 0/0", fill, pair_valid); end
        $display("[TB] test_basic_pair done");
    endtask

    task automatic test_overflow();
        logic [31:0] a, b;
        do_clr();
        for (int i = 0; i < 2*DEPTH+4; i++) feed(wd(i), 1'b0);
        tests_run++; if (fill !== 3'd4) begin tests_failed++; $display("FAIL ovf_fill got=%0d exp=4", fill); end
        tests_run++; if (drop_cnt !== 4'd2) begin tests_failed++; $display("FAIL ovf_drop got=%0d exp=2", drop_cnt); end
        for (int k = 0; k < DEPTH; k++) begin
            a = wd(2*k); b = wd(2*k+1);
            tests_run++; if (pair_valid !== 1'b1 || u0 !== exp_u0(a, b) || u1 !== exp_u1(b)) begin
                tests_failed++; $display("FAIL ovf_order%0d got v=%b u0=%h u1=%h exp u0=%h u1=%h", k, pair_valid, u0, u1, exp_u0(a, b), exp_u1(b)); end
            pop_one();
        end
        tests_run++; if (pair_valid !== 1'b0) begin tests_failed++; $display("FAIL ovf_drained got=%b exp=0", pair_valid); end
        a = wd(20); b = wd(21);
        feed(a, 1'b0);
        feed(b, 1'b0);
        tests_run++; if (u0 !== exp_u0(a, b) || u1 !== exp_u1(b) || fill !== 3'd1) begin
            tests_failed++; $display("FAIL ovf_align got u0=%h u1=%h fill=%0d exp u0=%h u1=%h fill=1", u0, u1, fill, exp_u0(a, b), exp_u1(b)); end
        $display("[TB] test_overflow done");
    endtask

    task automatic test_full_pop();
        logic [31:0] a, b;
        do_clr();
        for (int i = 0; i < 2*DEPTH; i++) feed(wd(i), 1'b0);
        feed(wd(8), 1'b0);
        feed(wd(9), 1'b1);
        tests_run++; if (fill !== 3'd4) begin tests_failed++; $display("FAIL fullpop_fill got=%0d exp=4", fill); end
        tests_run++; if (drop_cnt !== 4'd0) begin tests_failed++; $display("FAIL fullpop_drop got=%0d exp=0", drop_cnt); end
        for (int k = 1; k <= DEPTH; k++) begin
            a = wd(2*k); b = wd(2*k+1);
            tests_run++; if (pair_valid !== 1'b1 || u0 !== exp_u0(a, b) || u1 !== exp_u1(b)) begin
                tests_failed++; $display("FAIL fullpop_order%0d got v=%b u0=%h u1=%h exp u0=%h u1=%h", k, pair_valid, u0, u1, exp_u0(a, b), exp_u1(b)); end
            pop_one();
        end
        tests_run++; if (fill !== 3'd0) begin tests_failed++; $display("FAIL fullpop_empty got=%0d exp=0", fill); end
        $display("[TB] test_full_pop done");
    endtask

    task automatic test_zero_fix();
        do_clr();
        feed(32'h00000000, 1'b0);
        feed(32'h0000ABCD, 1'b0);
        tests_run++; if (u0 !== 48'h000000000001) begin tests_failed++; $display("FAIL zfix_u0 got=%h exp=000000000001", u0); end
        tests_run++; if (u1 !== 16'hABCD) begin tests_failed++; $display("FAIL zfix_u1 got=%h exp=abcd", u1); end
        tests_run++; if (fix_cnt !== 4'd1) begin tests_failed++; $display("FAIL zfix_cnt got=%0d exp=1", fix_cnt); end
        feed(32'h00000000, 1'b0);
        feed(32'h00010000, 1'b0);
        tests_run++; if (fix_cnt !== 4'd1 || fill !== 3'd2) begin tests_failed++; $display("FAIL zfix_nonzero got cnt=%0d fill=%0d exp 1/2", fix_cnt, fill); end
        $display("[TB] test_zero_fix done");
    endtask

    task automatic test_async_reset();
        do_clr();
        feed(32'hAAAA0000, 1'b0);
        feed(32'hBBBB1234, 1'b0);
        feed(32'hDEADBEEF, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        tests_run++; if (pair_valid !== 1'b0 || u0 !== 48'd0 || u1 !== 16'd0 || fill !== 3'd0) begin
            tests_failed++; $display("FAIL areset_now got v=%b u0=%h u1=%h fill=%0d exp 0/0/0/0", pair_valid, u0, u1, fill); end
        tick();
        reset = 1'b1;
        feed(32'h11111111, 1'b0);
        feed(32'h22222222, 1'b0);
        tests_run++; if (u0 !== 48'h111111112222 || u1 !== 16'h2222 || fill !== 3'd1) begin
            tests_failed++; $display("FAIL areset_after got u0=%h u1=%h fill=%0d exp 111111112222/2222/1", u0, u1, fill); end
        $display("[TB] test_async_reset done");
    endtask

    task automatic test_saturation();
        do_clr();
        for (int i = 0; i < 2*DEPTH; i++) feed(wd(i), 1'b0);
        for (int d = 1; d <= 20; d++) begin
            feed(wd(2*d), 1'b0);
            feed(wd(2*d+1), 1'b0);
            if (d == 14) begin
                tests_run++; if (drop_cnt !== 4'hE) begin tests_failed++; $display("FAIL sat_14 got=%h exp=e", drop_cnt); end
            end
            if (d == 15) begin
                tests_run++; if (drop_cnt !== 4'hF) begin tests_failed++; $display("FAIL sat_15 got=%h exp=f", drop_cnt); end
            end
        end
        tests_run++; if (drop_cnt !== 4'hF || fill !== 3'd4) begin tests_failed++; $display("FAIL sat_20 got drop=%h fill=%0d exp f/4", drop_cnt, fill); end
        do_clr();
        tests_run++; if (drop_cnt !== 4'd0 || fill !== 3'd0 || pair_valid !== 1'b0) begin
            tests_failed++; $display("FAIL sat_clr got drop=%h fill=%0d v=%b exp 0/0/0", drop_cnt, fill, pair_valid); end
        $display("[TB] test_saturation done");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        clr          = 1'b0;
        in_valid     = 1'b0;
        in_data      = 32'd0;
        pair_ready   = 1'b0;
        test_reset();
        test_basic_pair();
        test_overflow();
        test_full_pop();
        test_zero_fix();
        test_async_reset();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
